// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counting stage.
// Digit limits, FSM encoding and the packed six-digit time bundle.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_LAP
    } sw_state_e;

    localparam int unsigned DIG_MAX9    = 9;
    localparam int unsigned DIG_MAX5    = 5;
    localparam int unsigned MIN_MAX_DEF = 59;

    typedef struct packed {
        logic [3:0] min_hi;
        logic [3:0] min_lo;
        logic [3:0] sec_hi;
        logic [3:0] sec_lo;
        logic [3:0] hund_hi;
        logic [3:0] hund_lo;
    } bcd_time_t;

endpackage

// File: rtl/stopwatch_core_bcd_digit_cnt.sv
// Single BCD digit counting 0..LIMIT, wrapping to 0.
// Synchronous clear has priority over the enable.
module bcd_digit_cnt #(
    parameter int unsigned LIMIT = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       at_max
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (en) begin
            q_d = (q_q == LIM) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign at_max = (q_q == LIM);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch counting stage: 100 Hz edge detect, MM:SS.hh BCD chain,
// start/stop/lap FSM, lap freeze register and display mux.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned MIN_MAX = MIN_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_100hz,
    input  logic       strtstop,
    input  logic       lap_load,
    output logic [3:0] hund_lo,
    output logic [3:0] hund_hi,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       lap_active
);

    localparam logic [3:0] MIN_LO_W = 4'(MIN_MAX % 10);

    sw_state_e state_q;
    sw_state_e state_d;
    logic      tick_q;
    bcd_time_t lap_q;
    bcd_time_t lap_d;
    bcd_time_t live;
    bcd_time_t disp;

    logic       rise;
    logic       count_en;
    logic       lap_cap;
    logic       clr_live;
    logic       wrap;
    logic       dig_clr;
    logic [5:0] en;
    logic [5:0] mx;
    logic [3:0] dq [6];

    assign rise     = tick_100hz & ~tick_q;
    assign count_en = rise & ((state_q == ST_RUN) | (state_q == ST_LAP));
    assign lap_cap  = (state_q == ST_RUN) & lap_load & ~strtstop;
    assign clr_live = (state_q == ST_PAUSE) & lap_load & ~strtstop;

    // Digit order: hund_lo, hund_hi, sec_lo, sec_hi, min_lo, min_hi
    assign en[0] = count_en;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_dig
            localparam int unsigned LIM =
                (gi == 3) ? DIG_MAX5 :
                (gi == 5) ? (MIN_MAX / 10) : DIG_MAX9;

            if (gi > 0) begin : g_en
                assign en[gi] = en[gi-1] & mx[gi-1];
            end

            bcd_digit_cnt #(
                .LIMIT (LIM)
            ) u_dig (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (dig_clr),
                .en     (en[gi]),
                .q      (dq[gi]),
                .at_max (mx[gi])
            );
        end
    endgenerate

    // Minutes may top out below 99, so the full wrap is detected here
    assign wrap    = en[4] & mx[5] & (dq[4] == MIN_LO_W);
    assign dig_clr = clr_live | wrap;

    assign live = '{
        min_hi:  dq[5],
        min_lo:  dq[4],
        sec_hi:  dq[3],
        sec_lo:  dq[2],
        hund_hi: dq[1],
        hund_lo: dq[0]
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= 1'b1;
            lap_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_100hz;
            lap_q   <= lap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (strtstop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (strtstop)      state_d = ST_PAUSE;
                else if (lap_load) state_d = ST_LAP;
            end
            ST_LAP: begin
                if (strtstop)      state_d = ST_PAUSE;
                else if (lap_load) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (strtstop)      state_d = ST_RUN;
                else if (lap_load) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lap_d = lap_q;
        unique case (1'b1)
            clr_live: lap_d = '0;
            lap_cap:  lap_d = live;
            default:  lap_d = lap_q;
        endcase
    end

    always_comb begin
        running    = 1'b0;
        lap_active = 1'b0;
        disp       = live;
        case (state_q)
            ST_RUN: begin
                running = 1'b1;
            end
            ST_LAP: begin
                running    = 1'b1;
                lap_active = 1'b1;
                disp       = lap_q;
            end
            default: begin
                running = 1'b0;
            end
        endcase
    end

    assign hund_lo = disp.hund_lo;
    assign hund_hi = disp.hund_hi;
    assign sec_lo  = disp.sec_lo;
    assign sec_hi  = disp.sec_hi;
    assign min_lo  = disp.min_lo;
    assign min_hi  = disp.min_hi;

endmodule
